// File: rtl/anim_frame_ctrl_if.sv
// Bundle of the controller's datapath/VGA-side signals.
// master: the frame controller; slave: the game datapath / VGA adapter side.
interface anim_frame_ctrl_if #(
    parameter int N_OBJ     = 4,
    parameter int OBJ_IDX_W = 2,
    parameter int PIX_W     = 4
);
    logic                 pause;
    logic [N_OBJ-1:0]     touch_edge;
    logic                 plot_ready;
    logic [OBJ_IDX_W-1:0] obj_sel;
    logic [PIX_W-1:0]     pix_idx;
    logic [1:0]           op;
    logic                 datapath_en;
    logic                 move_en;
    logic                 load_coord;
    logic                 frame_tick;
    logic                 game_over;

    modport master (
        input  pause, touch_edge, plot_ready,
        output obj_sel, pix_idx, op, datapath_en, move_en,
               load_coord, frame_tick, game_over
    );

    modport slave (
        output pause, touch_edge, plot_ready,
        input  obj_sel, pix_idx, op, datapath_en, move_en,
               load_coord, frame_tick, game_over
    );
endinterface

// File: rtl/anim_frame_ctrl.sv
// Frame-sequencing controller for the VGA animation path: draws N_OBJ
// sprites pixel by pixel, checks for edge collision, waits one frame,
// erases, loads new coordinates and repeats. A collision enters a timed
// game-over hold that restarts play by itself.
module anim_frame_ctrl #(
    parameter int N_OBJ            = 4,
    parameter int OBJ_IDX_W        = 2,
    parameter int PIX_PER_OBJ      = 16,
    parameter int PIX_W            = 4,
    parameter int WAIT_CYCLES      = 1666666,
    parameter int WAIT_W           = 21,
    parameter int OVER_HOLD_FRAMES = 30
) (
    input  logic              clk,
    input  logic              reset_n,
    anim_frame_ctrl_if.master bus
);

    localparam int HOLD_W = (OVER_HOLD_FRAMES > 1) ? $clog2(OVER_HOLD_FRAMES) : 1;

    localparam logic [OBJ_IDX_W-1:0] OBJ_LAST   = OBJ_IDX_W'(N_OBJ - 1);
    localparam logic [PIX_W-1:0]     PIX_LAST   = PIX_W'(PIX_PER_OBJ - 1);
    localparam logic [WAIT_W-1:0]    FRAME_LAST = WAIT_W'(WAIT_CYCLES - 1);
    localparam logic [HOLD_W-1:0]    HOLD_LAST  = HOLD_W'(OVER_HOLD_FRAMES - 1);

    typedef enum logic [2:0] {
        S_DRAW,
        S_CHECK_OVER,
        S_WAIT,
        S_ERASE,
        S_LOAD_COORD,
        S_GAME_OVER
    } state_t;

    state_t               state_q, state_d;
    logic [OBJ_IDX_W-1:0] obj_q,   obj_d;
    logic [PIX_W-1:0]     pix_q,   pix_d;
    logic [WAIT_W-1:0]    frame_q, frame_d;
    logic [HOLD_W-1:0]    hold_q,  hold_d;

    logic frame_run;
    logic frame_wrap;

    // The frame timer only advances while waiting or holding game-over, and
    // pause freezes it (including suppressing the wrap on the last count).
    assign frame_run  = ((state_q == S_WAIT) || (state_q == S_GAME_OVER)) && !bus.pause;
    assign frame_wrap = frame_run && (frame_q == FRAME_LAST);

    // Next-state, iterator, frame-timer and hold-counter logic.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        state_d = state_q;
        obj_d   = obj_q;
        pix_d   = pix_q;
        frame_d = frame_q;
        hold_d  = hold_q;

        if (frame_run) begin
            frame_d = frame_wrap ? '0 : frame_q + WAIT_W'(1);
        end

        case (state_q)
            S_DRAW, S_ERASE: begin
                if (bus.plot_ready) begin
                    if (pix_q == PIX_LAST) begin
                        pix_d = '0;
                        if (obj_q == OBJ_LAST) begin
                            obj_d   = '0;
                            state_d = (state_q == S_DRAW) ? S_CHECK_OVER : S_LOAD_COORD;
                        end else begin
                            obj_d = obj_q + OBJ_IDX_W'(1);
                        end
                    end else begin
                        pix_d = pix_q + PIX_W'(1);
                    end
                end
            end
            S_CHECK_OVER: begin
                state_d = (|bus.touch_edge) ? S_GAME_OVER : S_WAIT;
            end
            S_WAIT: begin
                if (frame_wrap) begin
                    state_d = S_ERASE;
                end
            end
            S_LOAD_COORD: begin
                state_d = S_DRAW;
            end
            S_GAME_OVER: begin
                if (frame_wrap) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        state_d = S_LOAD_COORD;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_DRAW;
            end
        endcase
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n) begin
            state_q <= S_DRAW;
            obj_q   <= '0;
            pix_q   <= '0;
            frame_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            obj_q   <= obj_d;
            pix_q   <= pix_d;
            frame_q <= frame_d;
            hold_q  <= hold_d;
        end
    end

    // Moore outputs decoded from the state register; frame_tick marks the wrap.
    assign bus.obj_sel     = obj_q;
    assign bus.pix_idx     = pix_q;
    assign bus.op          = (state_q == S_ERASE) ? 2'b01 : 2'b00;
    assign bus.datapath_en = (state_q == S_DRAW) || (state_q == S_ERASE);
    assign bus.move_en     = (state_q == S_DRAW) || (state_q == S_ERASE) || (state_q == S_WAIT);
    assign bus.load_coord  = (state_q == S_LOAD_COORD);
    assign bus.frame_tick  = frame_wrap;
    assign bus.game_over   = (state_q == S_GAME_OVER);

endmodule

// File: tb/tb_anim_frame_ctrl.sv
// Scoreboard bench for anim_frame_ctrl with a small configuration
// (2 sprites x 4 pixels, 4-cycle frame, 2-frame game-over hold).
// The driver pushes the expected outputs of each cycle; a monitor on the
// falling edge pops and compares them against the DUT.
module tb_anim_frame_ctrl;

    localparam int N_OBJ = 2;
    localparam int OBJ_IDX_W = 1;
    localparam int PIX_PER_OBJ = 4;
    localparam int PIX_W = 2;
    localparam int WAIT_CYCLES = 4;
    localparam int WAIT_W = 2;
    localparam int OVER_HOLD_FRAMES = 2;

    typedef enum int {P_DRAW, P_CHECK, P_WAIT, P_ERASE, P_LOAD, P_OVER} ph_t;

    typedef struct packed {
        logic       dp_en;
        logic       mv_en;
        logic [1:0] op;
        logic       load;
        logic       tick;
        logic       over;
        logic [0:0] obj;
        logic [1:0] pix;
    } exp_t;

    typedef struct {
        exp_t  v;
        string tag;
    } sb_entry_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    sb_entry_t sb_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int cyc_no = 0;

    anim_frame_ctrl_if #(.N_OBJ(N_OBJ), .OBJ_IDX_W(OBJ_IDX_W), .PIX_W(PIX_W)) bus ();

    anim_frame_ctrl #(
        .N_OBJ(N_OBJ), .OBJ_IDX_W(OBJ_IDX_W), .PIX_PER_OBJ(PIX_PER_OBJ),
        .PIX_W(PIX_W), .WAIT_CYCLES(WAIT_CYCLES), .WAIT_W(WAIT_W),
        .OVER_HOLD_FRAMES(OVER_HOLD_FRAMES)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    // Expected output word for a given phase, sprite/pixel index and tick.
    function automatic exp_t mk(input ph_t ph, input int o, input int p, input bit t);
        exp_t r;
        r = '0;
        case (ph)
            P_DRAW:  begin r.dp_en = 1'b1; r.mv_en = 1'b1; r.op = 2'b00; end
            P_ERASE: begin r.dp_en = 1'b1; r.mv_en = 1'b1; r.op = 2'b01; end
            P_WAIT:  r.mv_en = 1'b1;
            P_LOAD:  r.load = 1'b1;
            P_OVER:  r.over = 1'b1;
            default: r = '0;
        endcase
        r.obj  = 1'(o);
        r.pix  = 2'(p);
        r.tick = t;
        return r;
    endfunction

    // One clock cycle: after the edge, drive inputs and queue this cycle's expectation.
    task automatic cyc(input logic rn, input logic rdy, input logic pse,
                       input logic [1:0] te, input exp_t ex, input string tag);
        sb_entry_t e;
        @(posedge clk);
        #1;
        reset_n        = rn;
        bus.plot_ready = rdy;
        bus.pause      = pse;
        bus.touch_edge = te;
        e.v   = ex;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    // Full draw or erase pass with plot_ready held high.
    task automatic plot_pass(input ph_t ph, input logic pse, input logic [1:0] te, input string tag);
        for (int o = 0; o < N_OBJ; o++)
            for (int p = 0; p < PIX_PER_OBJ; p++)
                cyc(1'b1, 1'b1, pse, te, mk(ph, o, p, 1'b0), tag);
    endtask

    // Unpaused frame periods in WAIT or GAME_OVER; tick on the last cycle of each.
    task automatic frames(input ph_t ph, input int n, input logic [1:0] te, input string tag);
        for (int f = 0; f < n; f++)
            for (int i = 0; i < WAIT_CYCLES; i++)
                cyc(1'b1, 1'b1, 1'b0, te, mk(ph, 0, 0, i == WAIT_CYCLES - 1), tag);
    endtask

    // Monitor: compare DUT outputs against the queued expectation every cycle.
    always @(negedge clk) begin
        sb_entry_t e;
        exp_t act;
        cyc_no++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            act = {bus.datapath_en, bus.move_en, bus.op, bus.load_coord,
                   bus.frame_tick, bus.game_over, bus.obj_sel, bus.pix_idx};
            n_checks++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s @cycle %0d: got dp=%b mv=%b op=%b ld=%b tk=%b go=%b obj=%0d pix=%0d, expected dp=%b mv=%b op=%b ld=%b tk=%b go=%b obj=%0d pix=%0d",
                         e.tag, cyc_no, act.dp_en, act.mv_en, act.op, act.load, act.tick,
                         act.over, act.obj, act.pix, e.v.dp_en, e.v.mv_en, e.v.op,
                         e.v.load, e.v.tick, e.v.over, e.v.obj, e.v.pix);
            end
        end
    end

    initial begin
        bus.plot_ready = 1'b0;
        bus.pause      = 1'b0;
        bus.touch_edge = '0;
        reset_n        = 1'b0;
        @(posedge clk);
        #1;

        // 1: reset state, then one full 22-cycle period back to DRAW.
        cyc(1'b1, 1'b1, 1'b0, 2'b00, mk(P_DRAW, 0, 0, 1'b0), "reset_state");
        for (int k = 1; k < N_OBJ * PIX_PER_OBJ; k++)
            cyc(1'b1, 1'b1, 1'b0, 2'b00, mk(P_DRAW, k / PIX_PER_OBJ, k % PIX_PER_OBJ, 1'b0), "t1_draw");
        cyc(1'b1, 1'b1, 1'b0, 2'b00, mk(P_CHECK, 0, 0, 1'b0), "t1_check");
        frames(P_WAIT, 1, 2'b00, "t1_wait");
        plot_pass(P_ERASE, 1'b0, 2'b00, "t1_erase");
        cyc(1'b1, 1'b1, 1'b0, 2'b00, mk(P_LOAD, 0, 0, 1'b0), "t1_load");

        // 2: plot_ready low for 3 cycles at the last pixel freezes everything.
        for (int o = 0; o < N_OBJ; o++)
            for (int p = 0; p < PIX_PER_OBJ; p++) begin
                if (o == 1 && p == 3)
                    repeat (3) cyc(1'b1, 1'b0, 1'b0, 2'b00, mk(P_DRAW, o, p, 1'b0), "t2_stall");
                cyc(1'b1, 1'b1, 1'b0, 2'b00, mk(P_DRAW, o, p, 1'b0), "t2_draw");
            end
        cyc(1'b1, 1'b1, 1'b0, 2'b00, mk(P_CHECK, 0, 0, 1'b0), "t2_check");
        frames(P_WAIT, 1, 2'b00, "t2_wait");
        plot_pass(P_ERASE, 1'b0, 2'b00, "t2_erase");
        cyc(1'b1, 1'b1, 1'b0, 2'b00, mk(P_LOAD, 0, 0, 1'b0), "t2_load");

        // 3: pause ignored in DRAW; 5 paused cycles at the last count stretch WAIT to 9.
        plot_pass(P_DRAW, 1'b1, 2'b00, "t3_draw_paused");
        cyc(1'b1, 1'b1, 1'b0, 2'b00, mk(P_CHECK, 0, 0, 1'b0), "t3_check");
        for (int i = 0; i < 9; i++)
            cyc(1'b1, 1'b1, (i >= 3 && i <= 7), 2'b00, mk(P_WAIT, 0, 0, i == 8), "t3_wait_pause");
        plot_pass(P_ERASE, 1'b0, 2'b00, "t3_erase");
        cyc(1'b1, 1'b1, 1'b0, 2'b00, mk(P_LOAD, 0, 0, 1'b0), "t3_load");

        // 4: collision at CHECK_OVER -> 8-cycle game-over hold, then restart.
        plot_pass(P_DRAW, 1'b0, 2'b00, "t4_draw");
        cyc(1'b1, 1'b1, 1'b0, 2'b10, mk(P_CHECK, 0, 0, 1'b0), "t4_check");
        frames(P_OVER, OVER_HOLD_FRAMES, 2'b00, "t4_over");
        cyc(1'b1, 1'b1, 1'b0, 2'b00, mk(P_LOAD, 0, 0, 1'b0), "t4_load");

        // 5: touch_edge outside CHECK_OVER is ignored.
        plot_pass(P_DRAW, 1'b0, 2'b11, "t5_draw");
        cyc(1'b1, 1'b1, 1'b0, 2'b00, mk(P_CHECK, 0, 0, 1'b0), "t5_check");
        frames(P_WAIT, 1, 2'b11, "t5_wait");
        plot_pass(P_ERASE, 1'b0, 2'b00, "t5_erase");
        cyc(1'b1, 1'b1, 1'b0, 2'b00, mk(P_LOAD, 0, 0, 1'b0), "t5_load");

        // 6: reset in ERASE at obj 1, pix 2 aborts to DRAW with indices cleared.
        plot_pass(P_DRAW, 1'b0, 2'b00, "t6_draw");
        cyc(1'b1, 1'b1, 1'b0, 2'b00, mk(P_CHECK, 0, 0, 1'b0), "t6_check");
        frames(P_WAIT, 1, 2'b00, "t6_wait");
        for (int k = 0; k < 6; k++)
            cyc(1'b1, 1'b1, 1'b0, 2'b00, mk(P_ERASE, k / PIX_PER_OBJ, k % PIX_PER_OBJ, 1'b0), "t6_erase");
        cyc(1'b0, 1'b1, 1'b0, 2'b00, mk(P_ERASE, 1, 2, 1'b0), "t6_erase_rst");
        plot_pass(P_DRAW, 1'b0, 2'b00, "t6_after_rst");
        cyc(1'b1, 1'b1, 1'b0, 2'b00, mk(P_CHECK, 0, 0, 1'b0), "t6_check2");
        frames(P_WAIT, 1, 2'b00, "t6_wait2");
        plot_pass(P_ERASE, 1'b0, 2'b00, "t6_erase2");
        cyc(1'b1, 1'b1, 1'b0, 2'b00, mk(P_LOAD, 0, 0, 1'b0), "t6_load");

        // 7: reset during game-over (hold=1, frame=1) clears both counters.
        plot_pass(P_DRAW, 1'b0, 2'b00, "t7_draw");
        cyc(1'b1, 1'b1, 1'b0, 2'b01, mk(P_CHECK, 0, 0, 1'b0), "t7_check");
        frames(P_OVER, 1, 2'b00, "t7_over");
        cyc(1'b1, 1'b1, 1'b0, 2'b00, mk(P_OVER, 0, 0, 1'b0), "t7_over2");
        cyc(1'b0, 1'b1, 1'b0, 2'b00, mk(P_OVER, 0, 0, 1'b0), "t7_over_rst");
        plot_pass(P_DRAW, 1'b0, 2'b00, "t7_after_rst");
        cyc(1'b1, 1'b1, 1'b0, 2'b01, mk(P_CHECK, 0, 0, 1'b0), "t7_check2");
        frames(P_OVER, OVER_HOLD_FRAMES, 2'b00, "t7_over_full");
        cyc(1'b1, 1'b1, 1'b0, 2'b00, mk(P_LOAD, 0, 0, 1'b0), "t7_load");
        cyc(1'b1, 1'b1, 1'b0, 2'b00, mk(P_DRAW, 0, 0, 1'b0), "t7_restart");

        // Let the monitor drain the scoreboard, then confirm nothing was left unchecked.
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
